dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
- Sits between decode and the even/odd pipe register-fetch stage.
- Accepts one decoded instruction pair per handshake and steers each instruction to the pipe its type selects.
- Tracks in-flight destination registers in a 128-entry latency scoreboard; issues both instructions when legal, otherwise splits the pair or stalls.
- Replaces per-stage destination comparison with a countdown scoreboard; counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 7, register address width (128 registers)
- LAT_W, 4, latency field width
- INSTR_W, 32, instruction payload width
- STALL_CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- pair_valid  in  1  decode presents a pair
- pair_ready  out  1  scheduler accepts the pair this cycle
- sN_instr  in  [0:INSTR_W-1]  payload, slot N=1,2 (slot 1 is older)
- sN_type  in  1  0=even pipe, 1=odd pipe
- sN_ra, sN_rb, sN_rc  in  [0:REG_AW-1]  source addresses
- sN_src_used  in  [0:2]  valid mask for ra/rb/rc
- sN_rt  in  [0:REG_AW-1]  destination address
- sN_rt_wr  in  1  instruction writes rt
- sN_lat  in  [0:LAT_W-1]  result latency in cycles, 1..7
- flush  in  1  branch flush; discard held instructions
- even_valid, odd_valid  out  1  issue strobe per pipe
- even_instr, odd_instr  out  [0:INSTR_W-1]  issued payload
- even_rt, odd_rt  out  [0:REG_AW-1]; even_rt_wr, odd_rt_wr  out  1; even_lat, odd_lat  out  [0:LAT_W-1]
- stall  out  1  a held instruction could not issue this cycle
- stall_cycles  out  [0:STALL_CNT_W-1]  saturating stall count

Behaviour:
- Reset (reset_n=0 at a clk edge): all scoreboard counters 0; state EMPTY; all outputs 0, including stall_cycles. The same applies mid-operation: held instructions are dropped.
- Holding register states:
  - EMPTY: nothing held.
  - PAIR: both slots held.
  - SECOND: only slot 2 held.
- Scoreboard: cnt[r] is LAT_W bits.
  - Each cycle, every nonzero cnt decrements by 1.
  - An issue with rt_wr loads cnt[rt] = lat. The load overrides the decrement in the same cycle.
- Readiness:
  - src_ready(r): cnt[r]==0.
  - An instruction is ready when all used sources are ready and, if rt_wr, cnt[rt] <= lat. The second term prevents out-of-order WAW.
- Decision in PAIR:
  - dual issue if both slots are ready, s1_type != s2_type, there is no WAW (both rt_wr with equal rt), and there is no intra-pair RAW (s1_rt_wr and s1_rt matches any used source of slot 2) → EMPTY.
  - Else, if slot 1 is ready, issue slot 1 only → SECOND.
  - Else stall.
- Decision in SECOND:
  - Issue slot 2 if ready → EMPTY.
  - Else stall.
  - Slot 2 readiness sees slot 1's scoreboard write from the previous edge.
- pair_ready = !flush && (EMPTY, or PAIR with dual issue this cycle, or SECOND with slot 2 issuing this cycle).
  - An accepted pair loads the holding register at the edge → PAIR.
- Issue outputs are registered and appear the cycle after the decision. The valid outputs deassert in any cycle without an issue. Minimum latency from pair accept to issue strobe is 2 cycles.
- stall=1 when the state is PAIR or SECOND and nothing issues this cycle. A partial (split) issue is not a stall. stall_cycles increments on stall and saturates at all-ones.
- Flush:
  - At the edge: state → EMPTY; held instructions discarded; issue valids 0 next cycle.
  - Scoreboard continues counting, since in-flight writes still complete.
  - A flush takes priority over both issue and accept in the same cycle.
- lat=0 with rt_wr=1 is treated as lat=1.

Optional Feature:
- FORWARDING_EN: when defined, src_ready(r) is cnt[r] <= 1 (the value is forwarded from the final stage) and intra-pair RAW still splits.
- Without it, src_ready requires cnt[r]==0.

Test Plan:
- Reset, then pair {s1 even rt=5, s2 odd rt=6, independent} → even_valid=odd_valid=1 two cycles after accept; stall=0; cnt[5]=s1_lat.
- Pair with both slots even → slot 1 on even, then slot 2 on even one cycle later; stall stays 0; pair_ready=0 during the first cycle.
- Issue rt=10 with lat=6, then a pair whose s1 reads r10 → stall for 5 cycles (4 with FORWARDING_EN); stall_cycles=5 (4).
- Intra-pair RAW: s1 odd writes r3 with lat=2; s2 even reads r3 → split; s2 issues after cnt[3] reaches 0 (or reaches 1 with FORWARDING_EN).
- Flush while in SECOND with pair_valid=1 → no issue next cycle, pair_ready=0 that cycle, state EMPTY; a pending cnt continues decrementing to 0.
- reset_n=0 mid-stall with cnt[10]=4 → all cnt=0 and stall_cycles=0; the next dependent pair dual-issues immediately.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// Dual-issue pair scheduler: steers decoded pairs to even/odd pipes, gated by a countdown latency scoreboard.
// Optional macro FORWARDING_EN treats a source with one cycle left as ready.
module dual_issue_scheduler #(
  parameter int REG_AW      = 7,
  parameter int LAT_W       = 4,
  parameter int INSTR_W     = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pair_valid,
  output logic                   pair_ready,
  input  logic [INSTR_W-1:0]     s1_instr,
  input  logic                   s1_type,
  input  logic [REG_AW-1:0]      s1_ra,
  input  logic [REG_AW-1:0]      s1_rb,
  input  logic [REG_AW-1:0]      s1_rc,
  input  logic [2:0]             s1_src_used,
  input  logic [REG_AW-1:0]      s1_rt,
  input  logic                   s1_rt_wr,
  input  logic [LAT_W-1:0]       s1_lat,
  input  logic [INSTR_W-1:0]     s2_instr,
  input  logic                   s2_type,
  input  logic [REG_AW-1:0]      s2_ra,
  input  logic [REG_AW-1:0]      s2_rb,
  input  logic [REG_AW-1:0]      s2_rc,
  input  logic [2:0]             s2_src_used,
  input  logic [REG_AW-1:0]      s2_rt,
  input  logic                   s2_rt_wr,
  input  logic [LAT_W-1:0]       s2_lat,
  input  logic                   flush,
  output logic                   even_valid,
  output logic                   odd_valid,
  output logic [INSTR_W-1:0]     even_instr,
  output logic [INSTR_W-1:0]     odd_instr,
  output logic [REG_AW-1:0]      even_rt,
  output logic [REG_AW-1:0]      odd_rt,
  output logic                   even_rt_wr,
  output logic                   odd_rt_wr,
  output logic [LAT_W-1:0]       even_lat,
  output logic [LAT_W-1:0]       odd_lat,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {EMPTY, PAIR, SECOND} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               pipe;
    logic [REG_AW-1:0]  ra;
    logic [REG_AW-1:0]  rb;
    logic [REG_AW-1:0]  rc;
    logic [2:0]         used;
    logic [REG_AW-1:0]  rt;
    logic               rt_wr;
    logic [LAT_W-1:0]   lat;
  } slot_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [REG_AW-1:0]  rt;
    logic               rt_wr;
    logic [LAT_W-1:0]   lat;
  } issue_t;

  state_t                 r_state, w_state_nxt;
  slot_t                  r_s1, r_s2, w_in1, w_in2;
  issue_t                 r_even, r_odd, w_even, w_odd;
  logic [LAT_W-1:0]       r_cnt [NREG];
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic w_s1_rdy, w_s2_rdy, w_raw, w_waw, w_dual, w_iss1, w_iss2, w_hold_done, w_accept;

  function automatic logic src_ok(input logic [LAT_W-1:0] c);
`ifdef FORWARDING_EN
    return c <= LAT_W'(1);
`else
    return c == '0;
`endif
  endfunction

  // A zero latency on a writer would never protect its result, so it is held as one cycle.
  function automatic slot_t pack_slot(
    input logic [INSTR_W-1:0] instr, input logic pipe,
    input logic [REG_AW-1:0] ra, input logic [REG_AW-1:0] rb, input logic [REG_AW-1:0] rc,
    input logic [2:0] used, input logic [REG_AW-1:0] rt, input logic rt_wr,
    input logic [LAT_W-1:0] lat);
    slot_t s;
    s.instr = instr;
    s.pipe  = pipe;
    s.ra    = ra;
    s.rb    = rb;
    s.rc    = rc;
    s.used  = used;
    s.rt    = rt;
    s.rt_wr = rt_wr;
    s.lat   = (lat == '0) ? LAT_W'(1) : lat;
    return s;
  endfunction

  function automatic issue_t mk_issue(input slot_t s);
    issue_t v;
    v.valid = 1'b1;
    v.instr = s.instr;
    v.rt    = s.rt;
    v.rt_wr = s.rt_wr;
    v.lat   = s.lat;
    return v;
  endfunction

  assign w_in1 = pack_slot(s1_instr, s1_type, s1_ra, s1_rb, s1_rc, s1_src_used, s1_rt, s1_rt_wr, s1_lat);
  assign w_in2 = pack_slot(s2_instr, s2_type, s2_ra, s2_rb, s2_rc, s2_src_used, s2_rt, s2_rt_wr, s2_lat);

  assign w_s1_rdy = (!r_s1.used[0] || src_ok(r_cnt[r_s1.ra])) &&
                    (!r_s1.used[1] || src_ok(r_cnt[r_s1.rb])) &&
                    (!r_s1.used[2] || src_ok(r_cnt[r_s1.rc])) &&
                    (!r_s1.rt_wr || (r_cnt[r_s1.rt] <= r_s1.lat));
  assign w_s2_rdy = (!r_s2.used[0] || src_ok(r_cnt[r_s2.ra])) &&
                    (!r_s2.used[1] || src_ok(r_cnt[r_s2.rb])) &&
                    (!r_s2.used[2] || src_ok(r_cnt[r_s2.rc])) &&
                    (!r_s2.rt_wr || (r_cnt[r_s2.rt] <= r_s2.lat));

  assign w_raw = r_s1.rt_wr && ((r_s2.used[0] && (r_s2.ra == r_s1.rt)) ||
                                (r_s2.used[1] && (r_s2.rb == r_s1.rt)) ||
                                (r_s2.used[2] && (r_s2.rc == r_s1.rt)));
  assign w_waw = r_s1.rt_wr && r_s2.rt_wr && (r_s1.rt == r_s2.rt);

  assign w_dual      = (r_state == PAIR) && w_s1_rdy && w_s2_rdy &&
                       (r_s1.pipe != r_s2.pipe) && !w_waw && !w_raw;
  assign w_iss1      = !flush && (r_state == PAIR) && w_s1_rdy;
  assign w_iss2      = !flush && (w_dual || ((r_state == SECOND) && w_s2_rdy));
  assign w_hold_done = (r_state == EMPTY) || w_dual || ((r_state == SECOND) && w_s2_rdy);
  assign pair_ready  = reset_n && !flush && w_hold_done;
  assign w_accept    = pair_valid && pair_ready;
  assign stall       = reset_n && !flush && (r_state != EMPTY) && !w_iss1 && !w_iss2;

  always_comb begin
    w_state_nxt = r_state;
    if (flush)                                       w_state_nxt = EMPTY;
    else if (w_accept)                               w_state_nxt = PAIR;
    else if (w_dual || ((r_state == SECOND) && w_iss2)) w_state_nxt = EMPTY;
    else if (w_iss1)                                 w_state_nxt = SECOND;
  end

  always_comb begin
    w_even = '0;
    w_odd  = '0;
    if (w_iss1) begin
      if (r_s1.pipe) w_odd  = mk_issue(r_s1);
      else           w_even = mk_issue(r_s1);
    end
    if (w_iss2) begin
      if (r_s2.pipe) w_odd  = mk_issue(r_s2);
      else           w_even = mk_issue(r_s2);
    end
  end

  // An issuing writer's load wins over the per-cycle countdown of the same entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - LAT_W'(1);
      if (w_iss1 && r_s1.rt_wr) r_cnt[r_s1.rt] <= r_s1.lat;
      if (w_iss2 && r_s2.rt_wr) r_cnt[r_s2.rt] <= r_s2.lat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= EMPTY;
      r_s1           <= '0;
      r_s2           <= '0;
      r_even         <= '0;
      r_odd          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_s1 <= w_in1;
        r_s2 <= w_in2;
      end
      r_even <= w_even;
      r_odd  <= w_odd;
      if (stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
    end
  end

  assign even_valid   = r_even.valid;
  assign even_instr   = r_even.instr;
  assign even_rt      = r_even.rt;
  assign even_rt_wr   = r_even.rt_wr;
  assign even_lat     = r_even.lat;
  assign odd_valid    = r_odd.valid;
  assign odd_instr    = r_odd.instr;
  assign odd_rt       = r_odd.rt;
  assign odd_rt_wr    = r_odd.rt_wr;
  assign odd_lat      = r_odd.lat;
  assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler; expected stall counts follow FORWARDING_EN when it is defined.
module tb_dual_issue_scheduler;
`ifdef FORWARDING_EN
  localparam int EXP_DEP_STALLS = 4;
  localparam int EXP_RAW_GAP    = 2;
  localparam int EXP_RAW_STALLS = 1;
`else
  localparam int EXP_DEP_STALLS = 5;
  localparam int EXP_RAW_GAP    = 3;
  localparam int EXP_RAW_STALLS = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n, pair_valid, pair_ready, flush;
  logic [31:0] s1_instr, s2_instr;
  logic        s1_type, s2_type, s1_rt_wr, s2_rt_wr;
  logic [6:0]  s1_ra, s1_rb, s1_rc, s1_rt, s2_ra, s2_rb, s2_rc, s2_rt;
  logic [2:0]  s1_src_used, s2_src_used;
  logic [3:0]  s1_lat, s2_lat;
  logic        even_valid, odd_valid, even_rt_wr, odd_rt_wr, stall;
  logic [31:0] even_instr, odd_instr;
  logic [6:0]  even_rt, odd_rt;
  logic [3:0]  even_lat, odd_lat;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  dual_issue_scheduler dut (
    .clk(clk), .reset_n(reset_n), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .s1_instr(s1_instr), .s1_type(s1_type), .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rc(s1_rc),
    .s1_src_used(s1_src_used), .s1_rt(s1_rt), .s1_rt_wr(s1_rt_wr), .s1_lat(s1_lat),
    .s2_instr(s2_instr), .s2_type(s2_type), .s2_ra(s2_ra), .s2_rb(s2_rb), .s2_rc(s2_rc),
    .s2_src_used(s2_src_used), .s2_rt(s2_rt), .s2_rt_wr(s2_rt_wr), .s2_lat(s2_lat),
    .flush(flush), .even_valid(even_valid), .odd_valid(odd_valid),
    .even_instr(even_instr), .odd_instr(odd_instr), .even_rt(even_rt), .odd_rt(odd_rt),
    .even_rt_wr(even_rt_wr), .odd_rt_wr(odd_rt_wr), .even_lat(even_lat), .odd_lat(odd_lat),
    .stall(stall), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearInputs();
    pair_valid = 1'b0; flush = 1'b0;
    s1_instr = '0; s1_type = 1'b0; s1_ra = '0; s1_rb = '0; s1_rc = '0;
    s1_src_used = '0; s1_rt = '0; s1_rt_wr = 1'b0; s1_lat = '0;
    s2_instr = '0; s2_type = 1'b0; s2_ra = '0; s2_rb = '0; s2_rc = '0;
    s2_src_used = '0; s2_rt = '0; s2_rt_wr = 1'b0; s2_lat = '0;
  endtask

  task automatic setSlot1(input logic t, input logic [6:0] ra, input logic [2:0] used,
                          input logic [6:0] rt, input logic wr, input logic [3:0] lat,
                          input logic [31:0] instr);
    s1_type = t; s1_ra = ra; s1_rb = 7'd0; s1_rc = 7'd0; s1_src_used = used;
    s1_rt = rt; s1_rt_wr = wr; s1_lat = lat; s1_instr = instr;
  endtask

  task automatic setSlot2(input logic t, input logic [6:0] ra, input logic [2:0] used,
                          input logic [6:0] rt, input logic wr, input logic [3:0] lat,
                          input logic [31:0] instr);
    s2_type = t; s2_ra = ra; s2_rb = 7'd0; s2_rc = 7'd0; s2_src_used = used;
    s2_rt = rt; s2_rt_wr = wr; s2_lat = lat; s2_instr = instr;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (even_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_even_valid got=%0b exp=0", even_valid); end
    vectors++; if (odd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_odd_valid got=%0b exp=0", odd_valid); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got=%0b exp=0", stall); end
    vectors++; if (stall_cycles !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
    vectors++; if (pair_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pair_ready got=%0b exp=0", pair_ready); end
    reset_n = 1'b1;
    #1;
    vectors++; if (pair_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_pair_ready got=%0b exp=1", pair_ready); end
  endtask

  task automatic test_dual_issue();
    setSlot1(1'b0, 7'd0, 3'b000, 7'd5, 1'b1, 4'd3, 32'h0000_00A1);
    setSlot2(1'b1, 7'd0, 3'b000, 7'd6, 1'b1, 4'd2, 32'h0000_00B2);
    pair_valid = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL dual_stall got=%0b exp=0", stall); end
    vectors++; if (pair_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL dual_pair_ready got=%0b exp=1", pair_ready); end
    vectors++; if (even_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL dual_early_even got=%0b exp=0", even_valid); end
    @(negedge clk);
    vectors++; if (even_valid !== 1'b1 || odd_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL dual_valids got=%0b%0b exp=11", even_valid, odd_valid); end
    vectors++; if (even_instr !== 32'hA1 || odd_instr !== 32'hB2) begin miscompares++; $display("[TB] FAIL dual_instr got=%0h/%0h exp=a1/b2", even_instr, odd_instr); end
    vectors++; if (even_rt !== 7'd5 || odd_rt !== 7'd6 || even_lat !== 4'd3) begin miscompares++; $display("[TB] FAIL dual_rt got=%0d/%0d lat=%0d exp=5/6 lat=3", even_rt, odd_rt, even_lat); end
    vectors++; if (dut.r_cnt[5] !== 4'd3) begin miscompares++; $display("[TB] FAIL dual_cnt5 got=%0d exp=3", dut.r_cnt[5]); end
    @(negedge clk);
    vectors++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL dual_idle got=%0b%0b exp=00", even_valid, odd_valid); end
  endtask

  task automatic test_same_pipe();
    setSlot1(1'b0, 7'd0, 3'b000, 7'd20, 1'b1, 4'd1, 32'h0000_00C3);
    setSlot2(1'b0, 7'd0, 3'b000, 7'd21, 1'b1, 4'd1, 32'h0000_00D4);
    pair_valid = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0;
    #1;
    vectors++; if (pair_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL split_pair_ready got=%0b exp=0", pair_ready); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL split_stall1 got=%0b exp=0", stall); end
    @(negedge clk);
    vectors++; if (even_valid !== 1'b1 || even_instr !== 32'hC3 || odd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL split_first got=%0b/%0h/%0b exp=1/c3/0", even_valid, even_instr, odd_valid); end
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL split_stall2 got=%0b exp=0", stall); end
    @(negedge clk);
    vectors++; if (even_valid !== 1'b1 || even_instr !== 32'hD4) begin miscompares++; $display("[TB] FAIL split_second got=%0b/%0h exp=1/d4", even_valid, even_instr); end
  endtask

  task automatic test_dependency_stall();
    int stalls;
    doReset();
    setSlot1(1'b0, 7'd0, 3'b000, 7'd10, 1'b1, 4'd6, 32'h0000_0011);
    setSlot2(1'b1, 7'd0, 3'b000, 7'd11, 1'b1, 4'd1, 32'h0000_0012);
    pair_valid = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0;
    @(negedge clk);
    vectors++; if (even_valid !== 1'b1 || even_instr !== 32'h11) begin miscompares++; $display("[TB] FAIL dep_producer got=%0b/%0h exp=1/11", even_valid, even_instr); end
    setSlot1(1'b0, 7'd10, 3'b001, 7'd13, 1'b1, 4'd2, 32'h0000_0021);
    setSlot2(1'b1, 7'd0, 3'b000, 7'd14, 1'b1, 4'd1, 32'h0000_0022);
    pair_valid = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall) break;
      stalls++;
      @(negedge clk);
    end
    vectors++; if (stalls != EXP_DEP_STALLS) begin miscompares++; $display("[TB] FAIL dep_stall_len got=%0d exp=%0d", stalls, EXP_DEP_STALLS); end
    vectors++; if (stall_cycles !== 16'(EXP_DEP_STALLS)) begin miscompares++; $display("[TB] FAIL dep_stall_cycles got=%0d exp=%0d", stall_cycles, EXP_DEP_STALLS); end
    @(negedge clk);
    vectors++; if (even_valid !== 1'b1 || odd_valid !== 1'b1 || even_instr !== 32'h21) begin miscompares++; $display("[TB] FAIL dep_issue got=%0b%0b/%0h exp=11/21", even_valid, odd_valid, even_instr); end
  endtask

  task automatic test_intra_raw();
    int gap;
    int stalls;
    doReset();
    setSlot1(1'b1, 7'd0, 3'b000, 7'd3, 1'b1, 4'd2, 32'h0000_0031);
    setSlot2(1'b0, 7'd3, 3'b001, 7'd4, 1'b1, 4'd1, 32'h0000_0032);
    pair_valid = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0;
    #1;
    vectors++; if (pair_ready !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("[TB] FAIL raw_split got ready=%0b stall=%0b exp=0/0", pair_ready, stall); end
    @(negedge clk);
    vectors++; if (odd_valid !== 1'b1 || odd_instr !== 32'h31 || even_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL raw_first got=%0b/%0h/%0b exp=1/31/0", odd_valid, odd_instr, even_valid); end
    gap = 0;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (stall) stalls++;
      @(negedge clk);
      gap++;
      if (even_valid) break;
    end
    vectors++; if (gap != EXP_RAW_GAP) begin miscompares++; $display("[TB] FAIL raw_gap got=%0d exp=%0d", gap, EXP_RAW_GAP); end
    vectors++; if (stalls != EXP_RAW_STALLS) begin miscompares++; $display("[TB] FAIL raw_stalls got=%0d exp=%0d", stalls, EXP_RAW_STALLS); end
    vectors++; if (even_instr !== 32'h32) begin miscompares++; $display("[TB] FAIL raw_second_instr got=%0h exp=32", even_instr); end
  endtask

  task automatic test_flush();
    doReset();
    setSlot1(1'b0, 7'd0, 3'b000, 7'd7, 1'b1, 4'd5, 32'h0000_0041);
    setSlot2(1'b0, 7'd7, 3'b001, 7'd8, 1'b1, 4'd1, 32'h0000_0042);
    pair_valid = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0;
    @(negedge clk);
    vectors++; if (even_valid !== 1'b1 || even_instr !== 32'h41) begin miscompares++; $display("[TB] FAIL flush_first got=%0b/%0h exp=1/41", even_valid, even_instr); end
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_wait_stall got=%0b exp=1", stall); end
    setSlot1(1'b0, 7'd0, 3'b000, 7'd9, 1'b1, 4'd1, 32'h0000_0051);
    flush = 1'b1;
    pair_valid = 1'b1;
    #1;
    vectors++; if (pair_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_pair_ready got=%0b exp=0", pair_ready); end
    @(negedge clk);
    flush = 1'b0;
    pair_valid = 1'b0;
    vectors++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_no_issue got=%0b%0b exp=00", even_valid, odd_valid); end
    #1;
    vectors++; if (pair_ready !== 1'b1 || stall !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_empty got ready=%0b stall=%0b exp=1/0", pair_ready, stall); end
    vectors++; if (dut.r_cnt[7] !== 4'd4) begin miscompares++; $display("[TB] FAIL flush_cnt7 got=%0d exp=4", dut.r_cnt[7]); end
    repeat (4) @(negedge clk);
    vectors++; if (dut.r_cnt[7] !== 4'd0 || even_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_drain got cnt=%0d ev=%0b exp=0/0", dut.r_cnt[7], even_valid); end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    setSlot1(1'b0, 7'd0, 3'b000, 7'd10, 1'b1, 4'd6, 32'h0000_0061);
    setSlot2(1'b1, 7'd0, 3'b000, 7'd11, 1'b1, 4'd1, 32'h0000_0062);
    pair_valid = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0;
    @(negedge clk);
    setSlot1(1'b0, 7'd10, 3'b001, 7'd13, 1'b1, 4'd2, 32'h0000_0071);
    setSlot2(1'b1, 7'd0, 3'b000, 7'd14, 1'b1, 4'd1, 32'h0000_0072);
    pair_valid = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0;
    @(negedge clk);
    #1;
    vectors++; if (stall !== 1'b1 || dut.r_cnt[10] !== 4'd4) begin miscompares++; $display("[TB] FAIL mid_pre got stall=%0b cnt=%0d exp=1/4", stall, dut.r_cnt[10]); end
    reset_n = 1'b0;
    @(negedge clk);
    vectors++; if (dut.r_cnt[10] !== 4'd0) begin miscompares++; $display("[TB] FAIL mid_cnt10 got=%0d exp=0", dut.r_cnt[10]); end
    vectors++; if (stall_cycles !== 16'd0 || stall !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_stall got cyc=%0d stall=%0b exp=0/0", stall_cycles, stall); end
    reset_n = 1'b1;
    pair_valid = 1'b1;
    #1;
    vectors++; if (pair_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_ready got=%0b exp=1", pair_ready); end
    @(negedge clk);
    pair_valid = 1'b0;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_nostall got=%0b exp=0", stall); end
    @(negedge clk);
    vectors++; if (even_valid !== 1'b1 || odd_valid !== 1'b1 || even_instr !== 32'h71 || odd_instr !== 32'h72) begin miscompares++; $display("[TB] FAIL mid_dual got=%0b%0b %0h/%0h exp=11 71/72", even_valid, odd_valid, even_instr, odd_instr); end
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_same_pipe();
    test_dependency_stall();
    test_intra_raw();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
